// File: rtl/uart_tx.sv
// uart_tx - 8N1 UART transmit serializer with 12-bit baud divisor and x16 oversampling.
// Frame parameters are latched at start so upstream can change them mid-frame.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        tx_load,
  input  logic [31:0] tx_data,
  input  logic [11:0] ubrr_in,
  output logic        txd,
  output logic        tx_comp,
  output logic        tx_busy
);

  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [11:0]          cnt_q, cnt_d;
  logic [11:0]          div_q, div_d;
  logic [OS_W-1:0]      os_q, os_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 txd_q, txd_d;
  logic                 comp_q, comp_d;
  logic                 busy_q, busy_d;
  logic                 tick;
  logic                 bit_end;

  logic unused_tx_data;
  assign unused_tx_data = ^tx_data[31:DATA_BITS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    os_d    = os_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    tick    = (cnt_q == div_q);
    bit_end = tick && (os_q == OS_LAST);

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        os_d  = '0;
        if (tx_load) begin
          sr_d    = tx_data[DATA_BITS-1:0];
          div_d   = ubrr_in;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START, S_DATA, S_STOP: begin
        if (tick) begin
          cnt_d = '0;
          os_d  = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
        if (bit_end) begin
          case (state_q)
            S_START: begin
              bit_d   = '0;
              state_d = S_DATA;
            end
            S_DATA: begin
              sr_d  = sr_q >> 1;
              bit_d = bit_q + 1'b1;
              if (bit_q == BIT_LAST) state_d = S_STOP;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DONE: begin
        cnt_d = '0;
        os_d  = '0;
        // Wait for the load level to drop so a stale request cannot start a second frame.
        if (!tx_load) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so derive them from the next-state values.
    busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = sr_d[0];
      default: txd_d = 1'b1;
    endcase
    // High during the cycle whose closing edge is the final stop-bit tick.
    comp_d = (state_d == S_STOP) && (os_d == OS_LAST) && (cnt_d == div_d);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      txd_q   <= 1'b1;
      comp_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      txd_q   <= txd_d;
      comp_q  <= comp_d;
      busy_q  <= busy_d;
    end
  end

  assign txd     = txd_q;
  assign tx_comp = comp_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx - directed frames for uart_tx checked against a frame-timing model every cycle.
module tb_uart_tx;

  logic        pclk;
  logic        preset;
  logic        tx_load;
  logic [31:0] tx_data;
  logic [11:0] ubrr_in;
  logic        txd;
  logic        tx_comp;
  logic        tx_busy;

  int total = 0;
  int bad   = 0;
  logic checking = 1'b0;

  uart_tx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .tx_load (tx_load),
    .tx_data (tx_data),
    .ubrr_in (ubrr_in),
    .txd     (txd),
    .tx_comp (tx_comp),
    .tx_busy (tx_busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 in frame (started at edge m_t0), 2 waiting for load to drop.
  int         cyc = 0;
  int         m_phase = 0;
  int         m_t0 = 0;
  int         m_d = 0;
  logic [7:0] m_b = '0;

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (preset) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (tx_load) begin
          m_phase <= 1;
          m_t0    <= cyc;
          m_d     <= int'(ubrr_in);
          m_b     <= tx_data[7:0];
        end
        1: if (cyc - m_t0 == 160 * (m_d + 1)) m_phase <= 2;
        default: if (!tx_load) m_phase <= 0;
      endcase
    end
  end

  // Returns {txd, tx_busy, tx_comp} expected c cycles into a frame with divisor d and byte b.
  function automatic logic [2:0] frame_out(input int c, input int d, input logic [7:0] b);
    int p;
    int n;
    logic bitv;
    p = 16 * (d + 1);
    n = c / p;
    if (n == 0) bitv = 1'b0;
    else if (n <= 8) bitv = b[n-1];
    else bitv = 1'b1;
    return {bitv, 1'b1, c == 10 * p - 1};
  endfunction

  always @(negedge pclk) begin
    if (checking) begin
      logic [2:0] e;
      if (m_phase == 1) e = frame_out(cyc - 1 - m_t0, m_d, m_b);
      else e = 3'b100;
      check("txd", {31'd0, txd}, {31'd0, e[2]});
      check("tx_busy", {31'd0, tx_busy}, {31'd0, e[1]});
      check("tx_comp", {31'd0, tx_comp}, {31'd0, e[0]});
    end
  end

  task automatic run_frame(input int d, input logic [31:0] data, input logic [7:0] exp_byte,
                           input int exp_comp, input int hold, input int chg_at);
    int p;
    int kc;
    logic [9:0] got;
    p   = 16 * (d + 1);
    kc  = -1;
    got = '0;
    @(negedge pclk);
    ubrr_in = d[11:0];
    tx_data = data;
    tx_load = 1'b1;
    for (int k = 0; k < exp_comp + 64 && kc < 0; k++) begin
      @(negedge pclk);
      if (k == chg_at) begin
        ubrr_in = 12'h007;
        tx_data = 32'h0000_0011;
      end
      for (int n = 0; n < 10; n++) if (k == n * p + p / 2) got[n] = txd;
      if (tx_comp) kc = k;
    end
    check("comp_cycle", kc, exp_comp);
    check("frame_bits", {22'd0, got}, {22'd0, 1'b1, exp_byte, 1'b0});
    repeat (hold) @(negedge pclk);
    check("no_retrigger", {30'd0, txd, tx_busy}, 32'h2);
    tx_load = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  initial begin
    preset  = 1'b1;
    tx_load = 1'b0;
    tx_data = '0;
    ubrr_in = 12'h144;
    @(posedge pclk);
    #1;
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_busy", {31'd0, tx_busy}, 32'd0);
    check("reset_comp", {31'd0, tx_comp}, 32'd0);
    checking = 1'b1;
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    repeat (3) @(negedge pclk);

    run_frame(0, 32'h0000_00A5, 8'hA5, 159, 1, -1);
    run_frame(12'h144, 32'h0000_003C, 8'h3C, 51999, 1, -1);
    run_frame(1, 32'hFFFF_FF00, 8'h00, 319, 5, -1);
    run_frame(0, 32'h0000_005A, 8'h5A, 159, 1, -1);
    run_frame(2, 32'h0000_00C3, 8'hC3, 479, 1, 200);

    // Reset in the middle of data bit 4 (cycles 80..95 at D=0).
    @(negedge pclk);
    ubrr_in = 12'h000;
    tx_data = 32'h0000_0096;
    tx_load = 1'b1;
    repeat (86) @(negedge pclk);
    preset  = 1'b1;
    tx_load = 1'b0;
    @(negedge pclk);
    check("midreset_txd", {31'd0, txd}, 32'd1);
    check("midreset_busy", {31'd0, tx_busy}, 32'd0);
    repeat (2) @(negedge pclk);
    preset = 1'b0;
    repeat (20) @(negedge pclk);
    run_frame(0, 32'h0000_0096, 8'h96, 159, 1, -1);

    repeat (4) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmit serializer that sits directly downstream of the UART register block. It consumes the held `tx_load` request, the `tx_data` word and the 12-bit `ubrr_out` baud divisor. It drives an 8N1 frame (start, 8 data bits LSB first, stop) on `txd`, then returns a one-cycle `tx_comp` pulse that the register block uses to clear its load, control and status bits.

## Interface
- `DATA_BITS`, 8: payload bits per frame, taken from `tx_data[DATA_BITS-1:0]`.
- `OVERSAMPLE`, 16: baud ticks per bit.
- `pclk` input 1: APB clock; the only clock, all logic on its rising edge.
- `preset` input 1: reset, synchronous and active-high.
- `tx_load` input 1: transmit request level; stays high from the TX write until the cycle after `tx_comp`.
- `tx_data` input 32: transmit word; only `[7:0]` is used; valid while `tx_load` is high.
- `ubrr_in` input 12: baud divisor D, driven from `ubrr_out`; reset value upstream is 0x144.
- `txd` output 1: serial line, idle high.
- `tx_comp` output 1: one-cycle pulse at the end of the stop bit.
- `tx_busy` output 1: high from the start bit through the stop bit.

## Operation
- States: IDLE, START, DATA, STOP, DONE.
- Baud tick generator:
  - 12-bit counter runs 0..D and asserts `tick` for one cycle when it equals D, then wraps to 0.
  - Bit period = OVERSAMPLE*(D+1) pclk cycles. D=0 gives 16 cycles per bit.
- Frame start, on IDLE with `tx_load`=1:
  - latch `tx_data[7:0]` into the shift register and `ubrr_in` into the divisor register;
  - clear the tick counter and the 4-bit oversample counter;
  - go to START.
  - Changes to `ubrr_in` or `tx_data` mid-frame have no effect on the current frame.
- START: `txd`=0. After 16 ticks go to DATA with bit index 0.
- DATA:
  - `txd` = shift register bit 0.
  - Every 16 ticks, shift right and increment the bit index.
  - After the bit with index 7 completes, go to STOP.
- STOP: `txd`=1. On the 16th tick assert `tx_comp` for that one cycle and go to DONE.
- DONE:
  - `txd`=1, `tx_busy`=0.
  - Stay until `tx_load`=0, then go to IDLE. This stops a stale `tx_load` from retriggering a frame, because upstream clears the load one cycle after `tx_comp`.
  - If `tx_load` is low already in the first DONE cycle, go to IDLE next edge.
- IDLE: `txd`=1; the tick counter is held at 0.
- `tx_busy` = 1 in START, DATA and STOP; 0 otherwise.
- All outputs are registered.
- Reset (any state, including mid-frame):
  - state IDLE, `txd`=1, `tx_comp`=0, `tx_busy`=0;
  - counters and shift register cleared;
  - a partial frame is abandoned; no `tx_comp` is issued.

## Timing
- Edge E0 samples IDLE and `tx_load`=1. From E0 onward: `txd`=0 and `tx_busy`=1.
- Each bit lasts exactly 16*(D+1) cycles.
- The `txd` transition for bit n (start = n 0, data bits n = 1..8, stop n = 9) occurs at E0 + n*16*(D+1).
- `tx_comp` is high for exactly one cycle, the last cycle of the stop bit, i.e. cycle E0 + 160*(D+1) - 1.
- After that cycle: DONE, `tx_busy`=0.
- Frame length is 160*(D+1) cycles. Minimum gap to the next start bit is 2 cycles:
  - DONE -> IDLE when `tx_load` drops;
  - IDLE -> START on the next rising `tx_load`.
- D=0xFFF is legal: 65536 cycles per bit; counters must not overflow.

## Test plan
- Reset: hold `preset`=1 for 3 cycles mid-simulation. Required: `txd`=1, `tx_busy`=0, `tx_comp`=0 after the first edge.
- Basic frame: `ubrr_in`=0, `tx_data`=0x000000A5, raise `tx_load`. Required:
  - `txd` = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 16 cycles;
  - `tx_comp` a single pulse at cycle 159 after start;
  - `tx_busy` low afterwards.
- Divisor: `ubrr_in`=0x144, `tx_data`=0x3C. Required: each bit lasts 5200 cycles; the frame decodes to 0x3C.
- Upper bits ignored and no retrigger:
  - `tx_data`=0xFFFFFF00 gives data bits all 0.
  - Hold `tx_load` high 5 cycles past `tx_comp`: no second frame until `tx_load` goes low then high again.
- Mid-frame changes: change `ubrr_in` and `tx_data` during DATA. Required: the frame keeps the original timing and byte.
- Mid-frame reset: assert `preset` during bit 4 of a frame. Required: `txd`=1 next edge, no `tx_comp`, and the next request transmits a clean full frame.
